sequence_generator: RTL and testbench

//   Free-running pseudo-random serial bit generator built on a Fibonacci LFSR.

---
 rtl/sequence_generator.sv | 64 ++++++
 tb/tb_sequence_generator.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/sequence_generator.sv
// Fibonacci LFSR serial bit source: reset loads SEED, init steps one shift per clock, out is the state MSB.
// Optional macro SEQGEN_LOCKUP_RECOVERY_EN reloads a nonzero state when the register sits at all-zero.
module sequence_generator #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] SEED  = 4'b1000,
    parameter logic [WIDTH-1:0] TAPS  = 4'b1100
) (
    input  logic clk,
    input  logic reset,
    input  logic init,
    output logic out
);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
            $fatal(1, "sequence_generator: WIDTH must be in 2..32");
        end
    endgenerate

`ifdef SEQGEN_LOCKUP_RECOVERY_EN
    // A zero SEED cannot restart the register, so fall back to the lowest nonzero state.
    localparam logic [WIDTH-1:0] RECOVERY_SEED = (SEED == '0) ? WIDTH'(1) : SEED;
`endif

    logic [WIDTH-1:0] s_reg;
    logic [WIDTH-1:0] s_next;
    logic [WIDTH-1:0] tap_bits;
    logic             fb;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_taps
            assign tap_bits[gi] = s_reg[gi] & TAPS[gi];
        end
    endgenerate

    assign fb = ^tap_bits;

    always_comb begin
        s_next = s_reg;
        if (init) begin
`ifdef SEQGEN_LOCKUP_RECOVERY_EN
            if (s_reg == '0) begin
                s_next = RECOVERY_SEED;
            end else begin
                s_next = {s_reg[WIDTH-2:0], fb};
            end
`else
            s_next = {s_reg[WIDTH-2:0], fb};
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_reg <= SEED;
        end else begin
            s_reg <= s_next;
        end
    end

    assign out = s_reg[WIDTH-1];

endmodule

// File: tb/tb_sequence_generator.sv
// Scoreboard bench for sequence_generator: a default-seed instance and a zero-seed instance run side by side.
module tb_sequence_generator;

    localparam logic [3:0] SEED = 4'b1000;
    localparam logic [3:0] TAPS = 4'b1100;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic init = 1'b0;
    logic out;
    logic out_z;

    always #5 clk = ~clk;

    sequence_generator #(.WIDTH(4), .SEED(SEED), .TAPS(TAPS)) dut (
        .clk(clk), .reset(reset), .init(init), .out(out)
    );

    sequence_generator #(.WIDTH(4), .SEED(4'b0000), .TAPS(TAPS)) dut_z (
        .clk(clk), .reset(reset), .init(init), .out(out_z)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_cyc = 0;
    bit exp_q[$];
    bit expz_q[$];
    logic [3:0] m_state;
    logic [3:0] mz_state;
    bit hist[30];

    function automatic logic [3:0] lfsr_adv(input logic [3:0] s, input logic [3:0] seed);
`ifdef SEQGEN_LOCKUP_RECOVERY_EN
        if (s == 4'b0000) return (seed == 4'b0000) ? 4'b0001 : seed;
`endif
        return {s[2:0], ^(s & TAPS)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one edge, push the model's prediction, then compare on the falling edge.
    task automatic cycle(input logic r, input logic i);
        reset = r;
        init  = i;
        if (r) begin
            m_state  = SEED;
            mz_state = 4'b0000;
        end else if (i) begin
            m_state  = lfsr_adv(m_state, SEED);
            mz_state = lfsr_adv(mz_state, 4'b0000);
        end
        exp_q.push_back(m_state[3]);
        expz_q.push_back(mz_state[3]);
        @(posedge clk);
        @(negedge clk);
        n_cyc++;
        $display("cyc %0d reset=%0b init=%0b out=%0b out_z=%0b", n_cyc, r, i, out, out_z);
        check("out", out, exp_q.pop_front());
        check("out_z", out_z, expz_q.pop_front());
    endtask

    initial begin
        bit golden[17];
        int ones;
        golden = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        m_state  = SEED;
        mz_state = 4'b0000;
        @(negedge clk);

        // Reset: one edge, then held for more edges
        cycle(1'b1, 1'b0);
        check("reset_state", dut.s_reg, 4'b1000);
        check("reset_out", out, 1'b1);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        check("reset_hold_out", out, 1'b1);

        // Full sequence against the literal table, including wrap-around
        cycle(1'b1, 1'b0);
        for (int k = 1; k < 17; k++) begin
            cycle(1'b0, 1'b1);
            check("seq_table", out, golden[k]);
        end
        check("wrap_state", dut.s_reg, 4'b0001);

        // Hold with init low
        cycle(1'b1, 1'b0);
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1);
        check("pre_hold_state", dut.s_reg, 4'b0011);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b0);
            check("hold_state", dut.s_reg, 4'b0011);
            check("hold_out", out, 1'b0);
        end
        cycle(1'b0, 1'b1);
        check("resume_state", dut.s_reg, 4'b0110);

        // Mid-run reset wins over init
        cycle(1'b1, 1'b0);
        for (int k = 0; k < 7; k++) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        check("midreset_state", dut.s_reg, 4'b1000);
        for (int k = 1; k < 5; k++) begin
            cycle(1'b0, 1'b1);
            check("restart_seq", out, golden[k]);
        end

        // Lock-up handling on the zero-seed instance
        cycle(1'b1, 1'b0);
        check("zero_reset_state", dut_z.s_reg, 4'b0000);
        cycle(1'b0, 1'b1);
`ifdef SEQGEN_LOCKUP_RECOVERY_EN
        check("lockup_recover", dut_z.s_reg, 4'b0001);
`else
        check("lockup_stuck", dut_z.s_reg, 4'b0000);
`endif
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1);

        // Period: every 15-bit window holds 8 ones and state never hits zero
        cycle(1'b1, 1'b0);
        hist[0] = out;
        for (int k = 1; k < 30; k++) begin
            cycle(1'b0, 1'b1);
            hist[k] = out;
            check("nonzero_state", (dut.s_reg != 4'b0000), 1'b1);
        end
        cycle(1'b0, 1'b1);
        for (int w = 0; w < 30; w += 15) begin
            ones = 0;
            for (int k = 0; k < 15; k++) ones += int'(hist[w + k]);
            check("ones_per_period", ones, 8);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
